// File: rtl/wb_mword_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_mword_fifo_pkg                                             |
// | Purpose  : Shared constants for the Wishbone multi-word FIFO: register   |
// |            address map, CSR bit positions and threshold width.           |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package wb_mword_fifo_pkg;

   // Word addresses on the Wishbone bus
   localparam logic [2:0] ADDR_R0  = 3'd0;
   localparam logic [2:0] ADDR_R1  = 3'd1;
   localparam logic [2:0] ADDR_R2  = 3'd2;
   localparam logic [2:0] ADDR_R3  = 3'd3;
   localparam logic [2:0] ADDR_CSR = 3'd4;
   localparam logic [2:0] ADDR_THR = 3'd5;

   // CSR bit positions
   localparam int CSR_FULL_BIT  = 16;
   localparam int CSR_EMPTY_BIT = 17;
   localparam int CSR_OVF_BIT   = 18;
   localparam int CSR_UDF_BIT   = 19;
   localparam int CSR_CLR_BIT   = 31;

   // Width of the threshold register and of the CSR fill-level field
   localparam int THR_W = 9;

   // Address of staging word k (k in 0..3)
   function automatic logic [2:0] stg_addr(input int k);
      case (k)
         0:       return ADDR_R0;
         1:       return ADDR_R1;
         2:       return ADDR_R2;
         default: return ADDR_R3;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mword_fifo_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mword_fifo_core                                               |
// | Purpose  : Entry storage, wrap-around pointers and fill level for the    |
// |            multi-word FIFO. Flush has priority over push and pop.        |
// | Ports    : clk_i/rst_n_i   clock, async active-low reset                 |
// |            push_i/data_i   enqueue request and entry                     |
// |            pop_i           dequeue request                               |
// |            flush_i         empty the FIFO                                |
// |            data_o/valid_o  popped entry (held) and one-cycle strobe      |
// |            usedw_o/full_o/empty_o  registered status                     |
// |            usedw_nxt_o     fill level being loaded this cycle            |
// |            ovf_o/udf_o     dropped push / ignored pop events             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mword_fifo_core #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   usedw_o,
   output logic [$clog2(DEPTH):0]   usedw_nxt_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic                     ovf_o,
   output logic                     udf_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int UW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [UW-1:0]    usedw_q, usedw_d;
   logic             full_q, empty_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             w_pop_ok, w_push_ok;

   // A pop in the same cycle frees the head slot, so a push onto a full
   // FIFO is accepted when it coincides with a successful pop.
   assign w_pop_ok  = pop_i  & ~empty_q & ~flush_i;
   assign w_push_ok = push_i & ~flush_i & (~full_q | w_pop_ok);
   assign ovf_o     = push_i & ~flush_i & full_q & ~w_pop_ok;
   assign udf_o     = pop_i  & ~flush_i & empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      usedw_d  = usedw_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         usedw_d  = '0;
      end else begin
         if (w_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (w_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   usedw_d = usedw_q + 1'b1;
            2'b01:   usedw_d = usedw_q - 1'b1;
            default: usedw_d = usedw_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         usedw_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         usedw_q  <= usedw_d;
         full_q   <= (usedw_d == UW'(DEPTH));
         empty_q  <= (usedw_d == '0);
         valid_q  <= w_pop_ok;
         if (w_pop_ok) data_q <= mem_q[rd_ptr_q];
      end
   end

   // Storage carries no reset; its contents are meaningless until written.
   always_ff @(posedge clk_i) begin
      if (w_push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign usedw_o     = usedw_q;
   assign usedw_nxt_o = usedw_d;
   assign full_o      = full_q;
   assign empty_o     = empty_q;

endmodule
`default_nettype wire

// File: rtl/wb_mword_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wb_mword_fifo                                                 |
// | Purpose  : Wishbone-written multi-word FIFO. The host fills a staging    |
// |            set R0..R(g_words-1); writing the last word commits the set   |
// |            as one entry. The device pops whole entries via rd_req_i.     |
// | Ports    : wb_*          classic Wishbone slave, word addressed          |
// |            rd_req_i      device pop request                              |
// |            rd_data_o     popped entry, word k at [32k+31:32k]            |
// |            rd_valid_o    one-cycle strobe for rd_data_o                  |
// |            full_o/empty_o/usedw_o  FIFO status                           |
// |            irq_o         fill level at or above nonzero threshold        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module wb_mword_fifo
   import wb_mword_fifo_pkg::*;
#(
   parameter int g_words       = 2,
   parameter int g_depth       = 16,
   parameter int g_irq_default = 0
) (
   input  logic                      wb_clk_i,
   input  logic                      rst_n_i,
   input  logic [2:0]                wb_addr_i,
   input  logic [31:0]               wb_data_i,
   output logic [31:0]               wb_data_o,
   input  logic                      wb_cyc_i,
   input  logic [3:0]                wb_sel_i,
   input  logic                      wb_stb_i,
   input  logic                      wb_we_i,
   output logic                      wb_ack_o,
   input  logic                      rd_req_i,
   output logic [32*g_words-1:0]     rd_data_o,
   output logic                      rd_valid_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [$clog2(g_depth):0]  usedw_o,
   output logic                      irq_o
);

   localparam int UW = $clog2(g_depth) + 1;

   logic                   ack_q;
   logic [31:0]            rdata_q, rdata_d;
   logic [31:0]            stg_q [g_words];
   logic                   ovf_q, ovf_d;
   logic                   udf_q, udf_d;
   logic [THR_W-1:0]       thr_q, thr_d;
   logic                   irq_q, irq_d;
   logic                   w_req, w_wr, w_csr_wr, w_flush, w_commit;
   logic                   w_ovf_evt, w_udf_evt;
   logic [32*g_words-1:0]  w_entry;
   logic [UW-1:0]          w_usedw_nxt;
   logic                   unused_sel;

   // Byte lanes are not supported: every write is a full word.
   assign unused_sel = ^wb_sel_i;

   assign w_req    = wb_cyc_i & wb_stb_i & ~ack_q;
   assign w_wr     = w_req & wb_we_i;
   assign w_csr_wr = w_wr && (wb_addr_i == ADDR_CSR);
   assign w_flush  = w_csr_wr && wb_data_i[CSR_CLR_BIT];
   assign w_commit = w_wr && (wb_addr_i == stg_addr(g_words - 1));

   // Staging words; the entry takes the last word straight from the bus so
   // the committing write's data lands in the same entry.
   for (genvar k = 0; k < g_words; k++) begin : g_stg
      always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
         if (!rst_n_i)
            stg_q[k] <= '0;
         else if (w_flush)
            stg_q[k] <= '0;
         else if (w_wr && (wb_addr_i == stg_addr(k)))
            stg_q[k] <= wb_data_i;
      end
      assign w_entry[32*k +: 32] = (k == g_words - 1) ? wb_data_i : stg_q[k];
   end

   mword_fifo_core #(
      .WIDTH (32 * g_words),
      .DEPTH (g_depth)
   ) u_core (
      .clk_i       (wb_clk_i),
      .rst_n_i     (rst_n_i),
      .push_i      (w_commit),
      .data_i      (w_entry),
      .pop_i       (rd_req_i),
      .flush_i     (w_flush),
      .data_o      (rd_data_o),
      .valid_o     (rd_valid_o),
      .usedw_o     (usedw_o),
      .usedw_nxt_o (w_usedw_nxt),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .ovf_o       (w_ovf_evt),
      .udf_o       (w_udf_evt)
   );

   // Sticky flags: a new event in the same cycle as a clear wins.
   always_comb begin
      ovf_d = ovf_q;
      udf_d = udf_q;
      thr_d = thr_q;
      if (w_flush) begin
         ovf_d = 1'b0;
         udf_d = 1'b0;
      end else begin
         if (w_csr_wr && wb_data_i[CSR_OVF_BIT]) ovf_d = 1'b0;
         if (w_csr_wr && wb_data_i[CSR_UDF_BIT]) udf_d = 1'b0;
         if (w_ovf_evt) ovf_d = 1'b1;
         if (w_udf_evt) udf_d = 1'b1;
      end
      if (w_wr && (wb_addr_i == ADDR_THR)) thr_d = wb_data_i[THR_W-1:0];
      // Evaluated on the next-state values so irq_o tracks usedw_o exactly.
      irq_d = (thr_d != '0) && (32'(w_usedw_nxt) >= 32'(thr_d));
   end

   always_comb begin
      rdata_d = '0;
      case (wb_addr_i)
         ADDR_CSR: begin
            rdata_d[CSR_UDF_BIT]   = udf_q;
            rdata_d[CSR_OVF_BIT]   = ovf_q;
            rdata_d[CSR_EMPTY_BIT] = empty_o;
            rdata_d[CSR_FULL_BIT]  = full_o;
            rdata_d[THR_W-1:0]     = THR_W'(usedw_o);
         end
         ADDR_THR: rdata_d[THR_W-1:0] = thr_q;
         default: begin
            for (int k = 0; k < g_words; k++)
               if (wb_addr_i == stg_addr(k)) rdata_d = stg_q[k];
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         thr_q   <= THR_W'(g_irq_default);
         irq_q   <= 1'b0;
      end else begin
         ack_q   <= w_req;
         if (w_req) rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         thr_q   <= thr_d;
         irq_q   <= irq_d;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_data_o = rdata_q;
   assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_mword_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_wb_mword_fifo                                              |
// | Purpose  : Self-checking bench for wb_mword_fifo (2 words, depth 4)      |
// |            against a queue-based reference model.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_wb_mword_fifo;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  wb_addr = '0;
   logic [31:0] wb_wdata = '0;
   logic [31:0] wb_rdata;
   logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
   logic [3:0]  wb_sel = 4'hF;
   logic        wb_ack;
   logic        rd_req = 1'b0;
   logic [63:0] rd_data;
   logic        rd_valid, full, empty, irq;
   logic [2:0]  usedw;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model
   logic [63:0] m_q[$];
   logic [31:0] m_stg[2];
   logic        m_ovf, m_udf;
   logic [8:0]  m_thr;

   always #5 clk = ~clk;

   wb_mword_fifo #(.g_words(2), .g_depth(D), .g_irq_default(0)) dut (
      .wb_clk_i(clk), .rst_n_i(rst_n), .wb_addr_i(wb_addr), .wb_data_i(wb_wdata),
      .wb_data_o(wb_rdata), .wb_cyc_i(wb_cyc), .wb_sel_i(wb_sel), .wb_stb_i(wb_stb),
      .wb_we_i(wb_we), .wb_ack_o(wb_ack), .rd_req_i(rd_req), .rd_data_o(rd_data),
      .rd_valid_o(rd_valid), .full_o(full), .empty_o(empty), .usedw_o(usedw), .irq_o(irq)
   );

   function automatic logic [31:0] exp_csr();
      logic [31:0] v = '0;
      v[19] = m_udf;
      v[18] = m_ovf;
      v[17] = (m_q.size() == 0);
      v[16] = (m_q.size() == D);
      v[8:0] = 9'(m_q.size());
      return v;
   endfunction

   function automatic logic exp_irq();
      return (m_thr != 0) && (m_q.size() >= int'(m_thr));
   endfunction

   function automatic logic [6:0] exp_status();
      return {3'(m_q.size()), m_q.size() == D, m_q.size() == 0, exp_irq(), 1'b0};
   endfunction

   function automatic logic [31:0] exp_read(input logic [2:0] a);
      case (a)
         3'd0: return m_stg[0];
         3'd1: return m_stg[1];
         3'd4: return exp_csr();
         3'd5: return {23'b0, m_thr};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_stg[0] = '0; m_stg[1] = '0;
      m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   // Commit of staging word 1 with an optional simultaneous pop.
   task automatic model_commit(input logic [31:0] hi, input bit pop,
                               output bit ev, output logic [63:0] ed);
      ev = 1'b0; ed = '0;
      if (pop) begin
         if (m_q.size() > 0) begin ev = 1'b1; ed = m_q.pop_front(); end
         else m_udf = 1'b1;
      end
      m_stg[1] = hi;
      if (m_q.size() < D) m_q.push_back({hi, m_stg[0]});
      else m_ovf = 1'b1;
   endtask

   task automatic model_pop(output bit ev, output logic [63:0] ed);
      ev = 1'b0; ed = '0;
      if (m_q.size() > 0) begin ev = 1'b1; ed = m_q.pop_front(); end
      else m_udf = 1'b1;
   endtask

   // One Wishbone cycle, optionally with rd_req in the request cycle.
   task automatic wb_cycle(input logic we, input logic [2:0] a, input logic [31:0] d,
                           input logic pop, output logic [31:0] q,
                           output logic v, output logic [63:0] rd);
      int i;
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d; rd_req = pop;
      @(negedge clk);
      v = rd_valid; rd = rd_data; rd_req = 1'b0;
      i = 0;
      while (!wb_ack && i < 4) begin @(negedge clk); i++; end
      n_checks++;
      if (!wb_ack || i != 0) begin
         n_errors++;
         $display("FAIL wb_ack_latency addr=%0d ack=%b extra_cycles=%0d required ack=1 extra_cycles=0", a, wb_ack, i);
      end
      q = wb_rdata;
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
   endtask

   task automatic pulse_pop(output logic v, output logic [63:0] rd);
      @(negedge clk);
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      v = rd_valid; rd = rd_data;
   endtask

   task automatic test_reset();
      logic [31:0] q; logic v; logic [63:0] rd;
      n_checks++;
      if ({wb_ack, rd_valid, rd_data, usedw, full, empty, irq} !== {1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_outputs got ack=%b val=%b data=%h usedw=%0d full=%b empty=%b irq=%b required 0,0,0,0,0,1,0",
                  wb_ack, rd_valid, rd_data, usedw, full, empty, irq);
      end
      wb_cycle(1'b0, 3'd4, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0002_0000) begin n_errors++; $display("FAIL reset_csr got %h required 00020000", q); end
      wb_cycle(1'b0, 3'd5, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0) begin n_errors++; $display("FAIL reset_thr got %h required 0", q); end
   endtask

   task automatic test_order();
      logic [31:0] q; logic v; logic [63:0] rd; bit ev; logic [63:0] ed;
      wb_cycle(1'b1, 3'd0, 32'h0, 1'b0, q, v, rd);  m_stg[0] = 32'h0;
      @(negedge clk);
      n_checks++;
      if (wb_ack !== 1'b0) begin n_errors++; $display("FAIL ack_single_cycle got %b required 0", wb_ack); end
      wb_cycle(1'b1, 3'd1, 32'h10, 1'b0, q, v, rd); model_commit(32'h10, 0, ev, ed);
      wb_cycle(1'b1, 3'd0, 32'h1, 1'b0, q, v, rd);  m_stg[0] = 32'h1;
      wb_cycle(1'b1, 3'd1, 32'h20, 1'b0, q, v, rd); model_commit(32'h20, 0, ev, ed);
      wb_cycle(1'b0, 3'd0, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h1) begin n_errors++; $display("FAIL staging_readback got %h required 1", q); end
      pulse_pop(v, rd); model_pop(ev, ed);
      n_checks++;
      if (v !== 1'b1 || rd !== 64'h00000010_00000000) begin
         n_errors++; $display("FAIL order_pop1 got v=%b d=%h required v=1 d=0000001000000000", v, rd);
      end
      pulse_pop(v, rd); model_pop(ev, ed);
      n_checks++;
      if (v !== 1'b1 || rd !== 64'h00000020_00000001) begin
         n_errors++; $display("FAIL order_pop2 got v=%b d=%h required v=1 d=0000002000000001", v, rd);
      end
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0 || empty !== 1'b1 || rd_data !== 64'h00000020_00000001) begin
         n_errors++; $display("FAIL order_after got v=%b empty=%b d=%h required v=0 empty=1 d held", rd_valid, empty, rd_data);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] q, lo, hi; logic v; logic [63:0] rd; bit ev; logic [63:0] ed;
      for (int i = 0; i < 5; i++) begin
         lo = $urandom; hi = $urandom;
         wb_cycle(1'b1, 3'd0, lo, 1'b0, q, v, rd); m_stg[0] = lo;
         wb_cycle(1'b1, 3'd1, hi, 1'b0, q, v, rd); model_commit(hi, 0, ev, ed);
         if (i == 3) begin
            n_checks++;
            if (full !== 1'b1) begin n_errors++; $display("FAIL full_after_4 got %b required 1", full); end
         end
      end
      wb_cycle(1'b0, 3'd4, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0005_0004) begin n_errors++; $display("FAIL csr_overflow got %h required 00050004", q); end
      wb_cycle(1'b1, 3'd4, 32'h0004_0000, 1'b0, q, v, rd); m_ovf = 1'b0;
      wb_cycle(1'b0, 3'd4, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0001_0004) begin n_errors++; $display("FAIL csr_ovf_clear got %h required 00010004", q); end
      for (int i = 0; i < 4; i++) begin
         pulse_pop(v, rd); model_pop(ev, ed);
         n_checks++;
         if (v !== ev || rd !== ed) begin n_errors++; $display("FAIL ovf_drain%0d got v=%b d=%h required v=%b d=%h", i, v, rd, ev, ed); end
      end
   endtask

   task automatic test_underflow();
      logic [31:0] q; logic v; logic [63:0] rd; bit ev; logic [63:0] ed;
      pulse_pop(v, rd); model_pop(ev, ed);
      n_checks++;
      if (v !== 1'b0) begin n_errors++; $display("FAIL underflow_valid got %b required 0", v); end
      wb_cycle(1'b0, 3'd4, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h000A_0000) begin n_errors++; $display("FAIL csr_underflow got %h required 000a0000", q); end
      wb_cycle(1'b1, 3'd4, 32'h0008_0000, 1'b0, q, v, rd); m_udf = 1'b0;
      wb_cycle(1'b0, 3'd4, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0002_0000) begin n_errors++; $display("FAIL csr_udf_clear got %h required 00020000", q); end
   endtask

   task automatic test_full_commit_pop();
      logic [31:0] q, lo, hi; logic v; logic [63:0] rd; bit ev; logic [63:0] ed;
      for (int i = 0; i < 5; i++) begin
         lo = $urandom; hi = $urandom;
         wb_cycle(1'b1, 3'd0, lo, 1'b0, q, v, rd); m_stg[0] = lo;
         wb_cycle(1'b1, 3'd1, hi, i == 4, q, v, rd); model_commit(hi, i == 4, ev, ed);
      end
      n_checks++;
      if (v !== 1'b1 || rd !== ed) begin n_errors++; $display("FAIL full_pop_data got v=%b d=%h required v=1 d=%h", v, rd, ed); end
      n_checks++;
      if (usedw !== 3'd4 || full !== 1'b1) begin n_errors++; $display("FAIL full_commit_pop_level got usedw=%0d full=%b required 4,1", usedw, full); end
      wb_cycle(1'b0, 3'd4, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0001_0004) begin n_errors++; $display("FAIL full_commit_pop_csr got %h required 00010004", q); end
      for (int i = 0; i < 4; i++) begin
         pulse_pop(v, rd); model_pop(ev, ed);
         n_checks++;
         if (v !== ev || rd !== ed) begin n_errors++; $display("FAIL fcp_drain%0d got v=%b d=%h required v=%b d=%h", i, v, rd, ev, ed); end
      end
   endtask

   task automatic test_irq();
      logic [31:0] q; logic v; logic [63:0] rd; bit ev; logic [63:0] ed;
      wb_cycle(1'b1, 3'd5, 32'd3, 1'b0, q, v, rd); m_thr = 9'd3;
      for (int i = 0; i < 3; i++) begin
         wb_cycle(1'b1, 3'd1, 32'hA0 + i, 1'b0, q, v, rd); model_commit(32'hA0 + i, 0, ev, ed);
         n_checks++;
         if (irq !== (i == 2)) begin n_errors++; $display("FAIL irq_commit%0d got %b required %b", i, irq, i == 2); end
      end
      pulse_pop(v, rd); model_pop(ev, ed);
      n_checks++;
      if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_fall got %b required 0", irq); end
      wb_cycle(1'b1, 3'd1, 32'hB0, 1'b0, q, v, rd); model_commit(32'hB0, 0, ev, ed);
      wb_cycle(1'b1, 3'd5, 32'd0, 1'b0, q, v, rd); m_thr = 9'd0;
      n_checks++;
      if (irq !== 1'b0 || usedw !== 3'd3) begin n_errors++; $display("FAIL irq_thr0 got irq=%b usedw=%0d required 0,3", irq, usedw); end
   endtask

   task automatic test_flush_pop();
      logic [31:0] q; logic v; logic [63:0] rd; bit ev; logic [63:0] ed;
      pulse_pop(v, rd); model_pop(ev, ed);   // leaves 2 entries queued
      wb_cycle(1'b1, 3'd4, 32'h8000_0000, 1'b1, q, v, rd); model_clear();
      n_checks++;
      if (v !== 1'b0 || usedw !== 3'd0 || empty !== 1'b1) begin
         n_errors++; $display("FAIL flush_wins got v=%b usedw=%0d empty=%b required 0,0,1", v, usedw, empty);
      end
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0) begin n_errors++; $display("FAIL flush_no_valid got %b required 0", rd_valid); end
      wb_cycle(1'b0, 3'd1, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0) begin n_errors++; $display("FAIL flush_staging got %h required 0", q); end
   endtask

   task automatic test_random();
      logic [31:0] q, lo, hi, d; logic v; logic [63:0] rd; bit ev, p; logic [63:0] ed;
      logic [2:0] a; int op;
      for (int it = 0; it < 200; it++) begin
         op = $urandom_range(0, 7);
         case (op)
            0, 1: begin
               lo = $urandom; hi = $urandom; p = ($urandom_range(0, 3) == 0);
               wb_cycle(1'b1, 3'd0, lo, 1'b0, q, v, rd); m_stg[0] = lo;
               wb_cycle(1'b1, 3'd1, hi, p, q, v, rd); model_commit(hi, p, ev, ed);
               n_checks++;
               if (v !== ev || (ev && rd !== ed)) begin n_errors++; $display("FAIL rnd_commit it=%0d got v=%b d=%h required v=%b d=%h", it, v, rd, ev, ed); end
            end
            2, 7: begin
               if (op == 7 && $urandom_range(0, 3) == 0) begin
                  wb_cycle(1'b1, 3'd4, 32'h8000_0000 | ($urandom & 32'h000C_0000), 1'b0, q, v, rd);
                  model_clear();
               end else begin
                  pulse_pop(v, rd); model_pop(ev, ed);
                  n_checks++;
                  if (v !== ev || (ev && rd !== ed)) begin n_errors++; $display("FAIL rnd_pop it=%0d got v=%b d=%h required v=%b d=%h", it, v, rd, ev, ed); end
               end
            end
            3, 5: begin
               a = (op == 3) ? 3'd4 : 3'($urandom_range(0, 7));
               wb_cycle(1'b0, a, 32'h0, 1'b0, q, v, rd);
               n_checks++;
               if (q !== exp_read(a)) begin n_errors++; $display("FAIL rnd_read it=%0d addr=%0d got %h required %h", it, a, q, exp_read(a)); end
            end
            4: begin
               d = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 5));
               wb_cycle(1'b1, 3'd5, d, 1'b0, q, v, rd); m_thr = d[8:0];
            end
            default: begin
               d = $urandom & 32'h7FFF_FFFF;
               wb_cycle(1'b1, 3'd4, d, 1'b0, q, v, rd);
               if (d[18]) m_ovf = 1'b0;
               if (d[19]) m_udf = 1'b0;
            end
         endcase
         n_checks++;
         if ({usedw, full, empty, irq, 1'b0} !== exp_status()) begin
            n_errors++; $display("FAIL rnd_status it=%0d got %b required %b", it, {usedw, full, empty, irq, 1'b0}, exp_status());
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] q; logic v; logic [63:0] rd; bit ev; logic [63:0] ed;
      wb_cycle(1'b1, 3'd4, 32'h8000_0000, 1'b0, q, v, rd); model_clear();
      wb_cycle(1'b1, 3'd5, 32'd1, 1'b0, q, v, rd); m_thr = 9'd1;
      for (int i = 0; i < 3; i++) begin
         wb_cycle(1'b1, 3'd1, 32'hC0 + i, 1'b0, q, v, rd); model_commit(32'hC0 + i, 0, ev, ed);
      end
      pulse_pop(v, rd); model_pop(ev, ed);
      @(negedge clk);
      wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_addr = 3'd1; wb_wdata = 32'hDEAD;
      @(posedge clk); #1;
      n_checks++;
      if (wb_ack !== 1'b1 || irq !== 1'b1) begin n_errors++; $display("FAIL pre_reset got ack=%b irq=%b required 1,1", wb_ack, irq); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({wb_ack, rd_valid, rd_data, usedw, full, empty, irq} !== {1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
         n_errors++;
         $display("FAIL async_reset got ack=%b val=%b data=%h usedw=%0d full=%b empty=%b irq=%b required 0,0,0,0,0,1,0",
                  wb_ack, rd_valid, rd_data, usedw, full, empty, irq);
      end
      wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      model_clear(); m_thr = 9'd0;
      wb_cycle(1'b0, 3'd5, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0) begin n_errors++; $display("FAIL thr_after_reset got %h required 0", q); end
      wb_cycle(1'b0, 3'd1, 32'h0, 1'b0, q, v, rd);
      n_checks++;
      if (q !== 32'h0) begin n_errors++; $display("FAIL staging_after_reset got %h required 0", q); end
   endtask

   initial begin
      model_clear();
      m_thr = 9'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_order();
      test_overflow();
      test_underflow();
      test_full_commit_pop();
      test_irq();
      test_flush_pop();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout reached required finish before it");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/wb_mword_fifo.md
WB_MWORD_FIFO -- requirements
Module: wb_mword_fifo

Interface
REQ-001 Parameter g_words, default 2: 32-bit words per FIFO entry, legal range 1..4.
REQ-002 Parameter g_depth, default 16: entries, power of 2, legal range 4..256.
REQ-003 Parameter g_irq_default, default 0: reset value of the threshold register.
REQ-004 Port wb_clk_i, in, 1: the single clock for all logic.
REQ-005 Port rst_n_i, in, 1: reset, asynchronous, active-low.
REQ-006 Ports wb_addr_i in 3, wb_data_i in 32, wb_data_o out 32, wb_cyc_i in 1, wb_sel_i in 4, wb_stb_i in 1, wb_we_i in 1, wb_ack_o out 1: classic Wishbone slave, word addressed.
REQ-007 Port rd_req_i, in, 1: device-side pop request.
REQ-008 Port rd_data_o, out, 32*g_words: popped entry; word k occupies bits [32k+31:32k].
REQ-009 Port rd_valid_o, out, 1: one-cycle strobe qualifying rd_data_o.
REQ-010 Ports full_o, empty_o (out, 1) and usedw_o (out, clog2(g_depth)+1): FIFO status.
REQ-011 Port irq_o, out, 1: level interrupt, fill level at or above threshold.

Function
REQ-012 Address map: 0..3 = staging word R0..R3, 4 = CSR, 5 = THR; 6..7 read 0, writes ignored.
REQ-013 wb_ack_o SHALL assert exactly one cycle after a cycle with cyc&stb&!ack, for one cycle; no wait states, no errors.
REQ-014 wb_sel_i is ignored; every write is a full 32-bit write.
REQ-015 A write to Rk with k<g_words SHALL load staging word k; k>=g_words is ignored and reads 0.
REQ-016 A write to R(g_words-1) SHALL commit the whole staging set, including that write's data, as one entry in the ack cycle.
REQ-017 Staging registers SHALL read back their last written value and SHALL NOT clear on commit.
REQ-018 CSR read: [31] 0, [19] underflow, [18] overflow, [17] empty, [16] full, [8:0] usedw zero-extended.
REQ-019 CSR write: bit31=1 flushes (pointers, usedw, overflow, underflow, staging set to 0); bit18=1 clears overflow; bit19=1 clears underflow; other bits ignored.
REQ-020 THR: bits [8:0] are R/W threshold; upper bits read 0.
REQ-021 A commit while full SHALL drop the entry, leave the FIFO unchanged and set sticky overflow.
REQ-022 rd_req_i while not empty SHALL pop the head; rd_data_o updates and rd_valid_o pulses in the next cycle; rd_data_o holds until the next pop.
REQ-023 rd_req_i while empty SHALL be ignored (no rd_valid_o) and SHALL set sticky underflow.
REQ-024 A commit and a pop in the same cycle SHALL both occur with usedw unchanged; when full, the pop frees the slot, so the commit is accepted.
REQ-025 A flush in the same cycle as a commit or pop SHALL win; the commit/pop is discarded and no rd_valid_o is generated.
REQ-026 Pointers SHALL wrap modulo g_depth; usedw ranges 0..g_depth; full when usedw==g_depth, empty when usedw==0.
REQ-027 full_o, empty_o and usedw_o SHALL be registered and reflect state after the last update, with the same value as the CSR fields.
REQ-028 irq_o SHALL be registered and equal (THR!=0) && (usedw>=THR).

Reset
REQ-029 On rst_n_i low, all of the following SHALL clear asynchronously: pointers, usedw_o=0, empty_o=1, full_o=0, rd_valid_o=0, rd_data_o=0, wb_ack_o=0, irq_o=0, sticky flags=0, staging=0, THR=g_irq_default.
REQ-030 A reset mid-transaction SHALL abort it; any in-progress commit is lost; FIFO memory contents are don't-care.

Structure
REQ-031 Package wb_mword_fifo_pkg holds the address constants (R0..R3, CSR, THR) and the CSR bit positions (FULL=16, EMPTY=17, OVF=18, UDF=19, CLR=31).
REQ-032 The storage, pointers and usedw SHALL be in one sub-module, mword_fifo_core (width, depth params; push, pop, flush inputs); the Wishbone decode stays in the top level.

Verification (g_words=2, g_depth=4)
REQ-033 Scenario 1: write R0=0, R1=0x10, then R0=1, R1=0x20, then pulse rd_req twice -> rd_data_o=0x00000010_00000000 then 0x00000020_00000001, one cycle after each req; empty_o=1 afterwards.
REQ-034 Scenario 2: perform 5 commits without pops -> full after the 4th; the 5th is dropped; CSR reads 0x00050004 (full, overflow, usedw=4); writing CSR=0x40000 clears the overflow bit.
REQ-035 Scenario 3: rd_req while empty -> no rd_valid_o; CSR bit19=1.
REQ-036 Scenario 4: with FIFO full, a commit coincident with rd_req -> both accepted; usedw stays 4; no overflow.
REQ-037 Scenario 5: THR=3, perform 3 commits -> irq_o rises after the 3rd; one pop -> irq_o falls; THR=0 -> irq_o stays low.
REQ-038 Scenario 6: 2 entries queued, CSR write 0x80000000 coincident with rd_req -> usedw=0, empty=1, no rd_valid_o; then assert rst_n_i low mid-Wishbone-cycle -> all outputs take their reset values immediately.
